mem_issue_pipe: RTL and testbench

MEM_ISSUE_PIPE -- requirements
Module: mem_issue_pipe

---
 rtl/mem_issue_pipe_pkg.sv | 35 +++
 rtl/mem_issue_lane.sv | 106 ++++++++++
 rtl/mem_issue_pipe.sv | 99 +++++++++
 tb/tb_mem_issue_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_issue_pipe_pkg.sv
// ----------------------------------------------------------------------------
// mem_issue_pipe_pkg
// Shared core types for the memory issue pipeline.
//   iprIdx_t        : physical register index
//   issueState_t    : payload carried from the issue queue to LDU/STU
//   REPLAY_BACKOFF_DEFAULT : busy cycles a port holds after a replay
//   count_ones()    : population count used by the optional perf counters
// ----------------------------------------------------------------------------
package mem_issue_pipe_pkg;

    localparam int IPR_IDX_W              = 6;
    localparam int IQ_IDX_W               = 4;
    localparam int REPLAY_BACKOFF_DEFAULT = 3;
    localparam int PERF_PORT_MAX          = 16;

    typedef logic [IPR_IDX_W-1:0] iprIdx_t;

    typedef struct packed {
        logic [3:0]          opcode;
        logic [11:0]         imm;
        iprIdx_t [1:0]       iprs;
        logic [IQ_IDX_W-1:0] iqIdx;
    } issueState_t;

    // Number of set bits in a port vector (ports beyond the real count are 0).
    function automatic logic [4:0] count_ones(input logic [PERF_PORT_MAX-1:0] vec);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < PERF_PORT_MAX; i++) begin
            cnt = cnt + {4'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mem_issue_lane.sv
// ----------------------------------------------------------------------------
// mem_issue_lane
// One memory issue port: i1 stage (regfile read), i2 stage (dispatch and
// feedback) and the post-replay backoff counter.
// Ports:
//   clk, rst (async active-low)
//   can_issue, issue_state           : i0 op from the issue queue
//   fu_busy                          : select block toward the issue queue
//   rf_ren, rf_iprs                  : i1 regfile read of iprs[0]
//   cancel_i1, cancel_i2, fu_stall   : kill sources
//   flush                            : squash everything in flight
//   fu_vld, fu_state                 : i2 dispatch to LDU/STU
//   issue_success, issue_replay, feedback_idx : i2 feedback
// ----------------------------------------------------------------------------
module mem_issue_lane
    import mem_issue_pipe_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int REPLAY_BACKOFF = REPLAY_BACKOFF_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     can_issue,
    input  issueState_t              issue_state,
    output logic                     fu_busy,
    output logic                     rf_ren,
    output iprIdx_t                  rf_iprs,
    input  logic                     cancel_i1,
    input  logic                     cancel_i2,
    input  logic                     fu_stall,
    input  logic                     flush,
    output logic                     fu_vld,
    output issueState_t              fu_state,
    output logic                     issue_success,
    output logic                     issue_replay,
    output logic [$clog2(DEPTH)-1:0] feedback_idx
);

    localparam int         IDX_W        = $clog2(DEPTH);
    localparam logic [2:0] BACKOFF_LOAD = 3'(REPLAY_BACKOFF);

    logic        i1_vld_r;
    issueState_t i1_state_r;
    logic        i2_vld_r;
    issueState_t i2_state_r;
    logic        i2_cancel_r;
    logic [2:0]  backoff_r;
    logic        kill_s;
    logic        live_s;

    // i0 -> i1 capture; never gated by fu_busy so a valid i0 op is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i1_vld_r   <= 1'b0;
            i1_state_r <= '0;
        end else begin
            i1_vld_r   <= can_issue & ~flush;
            i1_state_r <= issue_state;
        end
    end

    // i1 -> i2 advance; an i1 load-replay cancel is remembered as a sticky bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i2_vld_r    <= 1'b0;
            i2_state_r  <= '0;
            i2_cancel_r <= 1'b0;
        end else begin
            i2_vld_r    <= i1_vld_r & ~flush;
            i2_state_r  <= i1_state_r;
            i2_cancel_r <= i1_vld_r & cancel_i1;
        end
    end

    // A replay reloads the full backoff (no accumulation); flush clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            backoff_r <= 3'd0;
        end else if (issue_replay) begin
            backoff_r <= BACKOFF_LOAD;
        end else if (flush) begin
            backoff_r <= 3'd0;
        end else if (backoff_r != 3'd0) begin
            backoff_r <= backoff_r - 3'd1;
        end else begin
            backoff_r <= backoff_r;
        end
    end

    // i2 resolution: flush suppresses everything, kill turns success into replay.
    always_comb begin
        kill_s        = i2_cancel_r | cancel_i2 | fu_stall;
        live_s        = i2_vld_r & ~flush;
        issue_success = live_s & ~kill_s;
        issue_replay  = live_s & kill_s;
        fu_vld        = issue_success;
    end

    assign fu_state     = i2_state_r;
    assign feedback_idx = i2_state_r.iqIdx[IDX_W-1:0];
    assign rf_ren       = i1_vld_r;
    assign rf_iprs      = i1_state_r.iprs[0];
    // Gated by rst so the issue queue sees no block while the pipe is in reset.
    assign fu_busy      = rst & (fu_stall | (backoff_r != 3'd0));

endmodule

// File: rtl/mem_issue_pipe.sv
// ----------------------------------------------------------------------------
// mem_issue_pipe
// Two-stage (i1/i2) issue pipeline for INOUTPORT_NUM independent memory
// ports between the issue queue and the LDU/STU.
// Ports:
//   clk, rst (async active-low)
//   i_can_issue, i_issueState        : per-port i0 ops
//   o_fu_busy                        : per-port select block
//   o_rf_ren, o_rf_iprs              : per-port i1 regfile read
//   i_cancel_i1, i_cancel_i2, i_fu_stall, i_flush : kill / squash inputs
//   o_fu_vld, o_fu_issueState        : per-port i2 dispatch
//   o_issueSuccess, o_issueReplay, o_feedbackIdx : per-port i2 feedback
// Optional feature macro MEM_ISSUE_PERF_EN adds o_perf_success and
// o_perf_replay (32-bit wrapping totals over all ports).
// ----------------------------------------------------------------------------
module mem_issue_pipe
    import mem_issue_pipe_pkg::*;
#(
    parameter int INOUTPORT_NUM  = 2,
    parameter int DEPTH          = 8,
    parameter int REPLAY_BACKOFF = REPLAY_BACKOFF_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INOUTPORT_NUM-1:0] i_can_issue,
    input  issueState_t              i_issueState [INOUTPORT_NUM],
    output logic [INOUTPORT_NUM-1:0] o_fu_busy,
    output logic [INOUTPORT_NUM-1:0] o_rf_ren,
    output iprIdx_t                  o_rf_iprs [INOUTPORT_NUM],
    input  logic [INOUTPORT_NUM-1:0] i_cancel_i1,
    input  logic [INOUTPORT_NUM-1:0] i_cancel_i2,
    input  logic [INOUTPORT_NUM-1:0] i_fu_stall,
    input  logic                     i_flush,
    output logic [INOUTPORT_NUM-1:0] o_fu_vld,
    output issueState_t              o_fu_issueState [INOUTPORT_NUM],
    output logic [INOUTPORT_NUM-1:0] o_issueSuccess,
    output logic [INOUTPORT_NUM-1:0] o_issueReplay,
    output logic [$clog2(DEPTH)-1:0] o_feedbackIdx [INOUTPORT_NUM]
`ifdef MEM_ISSUE_PERF_EN
    ,
    output logic [31:0]              o_perf_success,
    output logic [31:0]              o_perf_replay
`endif
);

    for (genvar p = 0; p < INOUTPORT_NUM; p++) begin : g_lane
        mem_issue_lane #(
            .DEPTH          (DEPTH),
            .REPLAY_BACKOFF (REPLAY_BACKOFF)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .can_issue     (i_can_issue[p]),
            .issue_state   (i_issueState[p]),
            .fu_busy       (o_fu_busy[p]),
            .rf_ren        (o_rf_ren[p]),
            .rf_iprs       (o_rf_iprs[p]),
            .cancel_i1     (i_cancel_i1[p]),
            .cancel_i2     (i_cancel_i2[p]),
            .fu_stall      (i_fu_stall[p]),
            .flush         (i_flush),
            .fu_vld        (o_fu_vld[p]),
            .fu_state      (o_fu_issueState[p]),
            .issue_success (o_issueSuccess[p]),
            .issue_replay  (o_issueReplay[p]),
            .feedback_idx  (o_feedbackIdx[p])
        );
    end

`ifdef MEM_ISSUE_PERF_EN
    logic [PERF_PORT_MAX-1:0] success_ext_s;
    logic [PERF_PORT_MAX-1:0] replay_ext_s;
    logic [31:0]              perf_success_r;
    logic [31:0]              perf_replay_r;

    // Zero-extend the per-port feedback vectors to the popcount width.
    always_comb begin
        success_ext_s                      = '0;
        replay_ext_s                       = '0;
        success_ext_s[INOUTPORT_NUM-1:0]   = o_issueSuccess;
        replay_ext_s[INOUTPORT_NUM-1:0]    = o_issueReplay;
    end

    // Wrapping totals of successes and replays across all ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_success_r <= 32'd0;
            perf_replay_r  <= 32'd0;
        end else begin
            perf_success_r <= perf_success_r + {27'd0, count_ones(success_ext_s)};
            perf_replay_r  <= perf_replay_r + {27'd0, count_ones(replay_ext_s)};
        end
    end

    assign o_perf_success = perf_success_r;
    assign o_perf_replay  = perf_replay_r;
`endif

endmodule

// File: tb/tb_mem_issue_pipe.sv
// ----------------------------------------------------------------------------
// tb_mem_issue_pipe
// Directed scoreboard bench for mem_issue_pipe (2 ports, DEPTH 8, backoff 3).
// Stimulus pushes expected feedback (kind, index, cycle) per port; a negedge
// monitor pops and compares whenever success or replay is presented.
// ----------------------------------------------------------------------------
module tb_mem_issue_pipe;
    import mem_issue_pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  i_can_issue;
    issueState_t i_issueState [2];
    logic [1:0]  o_fu_busy;
    logic [1:0]  o_rf_ren;
    iprIdx_t     o_rf_iprs [2];
    logic [1:0]  i_cancel_i1;
    logic [1:0]  i_cancel_i2;
    logic [1:0]  i_fu_stall;
    logic        i_flush;
    logic [1:0]  o_fu_vld;
    issueState_t o_fu_issueState [2];
    logic [1:0]  o_issueSuccess;
    logic [1:0]  o_issueReplay;
    logic [2:0]  o_feedbackIdx [2];
`ifdef MEM_ISSUE_PERF_EN
    logic [31:0] o_perf_success;
    logic [31:0] o_perf_replay;
`endif

    mem_issue_pipe dut (
        .clk             (clk),
        .rst             (rst),
        .i_can_issue     (i_can_issue),
        .i_issueState    (i_issueState),
        .o_fu_busy       (o_fu_busy),
        .o_rf_ren        (o_rf_ren),
        .o_rf_iprs       (o_rf_iprs),
        .i_cancel_i1     (i_cancel_i1),
        .i_cancel_i2     (i_cancel_i2),
        .i_fu_stall      (i_fu_stall),
        .i_flush         (i_flush),
        .o_fu_vld        (o_fu_vld),
        .o_fu_issueState (o_fu_issueState),
        .o_issueSuccess  (o_issueSuccess),
        .o_issueReplay   (o_issueReplay),
        .o_feedbackIdx   (o_feedbackIdx)
`ifdef MEM_ISSUE_PERF_EN
        ,
        .o_perf_success  (o_perf_success),
        .o_perf_replay   (o_perf_replay)
`endif
    );

    typedef struct {
        logic       succ;
        logic [2:0] idx;
        int         cyc;
    } exp_t;

    exp_t sb_q0 [$];
    exp_t sb_q1 [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, advanced on each active edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic issueState_t mk_state(input logic [2:0] idx, input iprIdx_t pr);
        issueState_t s;
        s         = '0;
        s.iqIdx   = {1'b0, idx};
        s.iprs[0] = pr;
        s.iprs[1] = ~pr;
        s.opcode  = {1'b1, idx};
        return s;
    endfunction

    // Advance to just after the next active edge and return controls to idle.
    task automatic step();
        @(posedge clk);
        #1;
        i_can_issue = 2'b00;
        i_cancel_i1 = 2'b00;
        i_cancel_i2 = 2'b00;
        i_fu_stall  = 2'b00;
        i_flush     = 1'b0;
    endtask

    task automatic drive_op(input int p, input logic [2:0] idx, input iprIdx_t pr);
        i_can_issue[p]  = 1'b1;
        i_issueState[p] = mk_state(idx, pr);
    endtask

    // Feedback for an op issued this cycle is due exactly two cycles later.
    task automatic expect_fb(input int p, input logic succ, input logic [2:0] idx);
        exp_t e;
        e.succ = succ;
        e.idx  = idx;
        e.cyc  = cyc + 2;
        if (p == 0) sb_q0.push_back(e);
        else        sb_q1.push_back(e);
    endtask

    task automatic mon_port(input int p);
        exp_t        e;
        logic [37:0] got_v;
        logic [37:0] exp_v;
        bit          have;
        have = (p == 0) ? (sb_q0.size() > 0) : (sb_q1.size() > 0);
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL fb_unexpected port%0d cyc=%0d succ=%b repl=%b idx=%0d exp=none",
                     p, cyc, o_issueSuccess[p], o_issueReplay[p], o_feedbackIdx[p]);
            return;
        end
        if (p == 0) e = sb_q0.pop_front();
        else        e = sb_q1.pop_front();
        got_v = {o_issueSuccess[p], o_issueReplay[p], o_fu_vld[p], o_feedbackIdx[p], cyc};
        exp_v = {e.succ, ~e.succ, e.succ, e.idx, e.cyc};
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL fb_port%0d got succ/repl/vld=%b%b%b idx=%0d cyc=%0d exp succ/repl/vld=%b%b%b idx=%0d cyc=%0d",
                     p, o_issueSuccess[p], o_issueReplay[p], o_fu_vld[p], o_feedbackIdx[p], cyc,
                     e.succ, ~e.succ, e.succ, e.idx, e.cyc);
        end
    endtask

    // Monitor: whenever a port presents feedback, compare with the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                if (o_issueSuccess[p] || o_issueReplay[p]) mon_port(p);
            end
        end
    end

    initial begin
        rst             = 1'b0;
        i_can_issue     = 2'b00;
        i_cancel_i1     = 2'b00;
        i_cancel_i2     = 2'b00;
        i_fu_stall      = 2'b01;
        i_flush         = 1'b0;
        i_issueState[0] = '0;
        i_issueState[1] = '0;

        // Reset state: everything low, even with a stall request present.
        #2;
        check("rst_busy", {30'd0, o_fu_busy}, 32'd0);
        check("rst_ren", {30'd0, o_rf_ren}, 32'd0);
        check("rst_fb", {28'd0, o_issueSuccess, o_issueReplay}, 32'd0);
        check("rst_vld", {30'd0, o_fu_vld}, 32'd0);
        i_fu_stall = 2'b00;
        step();
        rst = 1'b1;
        step();

        // Clean issue on port 0, idx 5.
        drive_op(0, 3'd5, 6'd17);
        expect_fb(0, 1'b1, 3'd5);
        step();
        check("clean_ren0", {31'd0, o_rf_ren[0]}, 32'd1);
        check("clean_iprs0", {26'd0, o_rf_iprs[0]}, 32'd17);
        check("clean_ren1", {31'd0, o_rf_ren[1]}, 32'd0);
        step();
        check("clean_state_idx", {28'd0, o_fu_issueState[0].iqIdx}, 32'd5);
        step();

        // Back-to-back issue on port 0, four consecutive successes.
        for (int i = 0; i < 4; i++) begin
            step();
            drive_op(0, 3'(i + 1), 6'(i + 2));
            expect_fb(0, 1'b1, 3'(i + 1));
        end
        step();
        step();
        step();

        // i1 cancel on port 1, idx 3: replay then three busy cycles.
        drive_op(1, 3'd3, 6'd9);
        expect_fb(1, 1'b0, 3'd3);
        step();
        i_cancel_i1[1] = 1'b1;
        step();
        check("cancel_busy_pre", {31'd0, o_fu_busy[1]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin
                // Issue while busy: must still be captured and succeed.
                drive_op(1, 3'd2, 6'd4);
                expect_fb(1, 1'b1, 3'd2);
            end
            check("cancel_busy", {31'd0, o_fu_busy[1]}, (k < 3) ? 32'd1 : 32'd0);
        end
        step();
        step();

        // FU stall on port 0, back-to-back replays reload the counter to 3.
        drive_op(0, 3'd6, 6'd1);
        expect_fb(0, 1'b0, 3'd6);
        step();
        drive_op(0, 3'd7, 6'd2);
        expect_fb(0, 1'b0, 3'd7);
        step();
        i_fu_stall[0] = 1'b1;
        step();
        i_fu_stall[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_busy", {31'd0, o_fu_busy[0]}, (k < 3) ? 32'd1 : 32'd0);
        end

        // i2 cancel on port 1, idx 4.
        drive_op(1, 3'd4, 6'd3);
        expect_fb(1, 1'b0, 3'd4);
        step();
        step();
        i_cancel_i2[1] = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Flush with ops in i1 and i2 and a live backoff on port 1.
        drive_op(1, 3'd1, 6'd5);
        expect_fb(1, 1'b0, 3'd1);
        step();
        drive_op(1, 3'd2, 6'd6);
        step();
        i_cancel_i2[1] = 1'b1;
        drive_op(0, 3'd3, 6'd7);
        step();
        check("flush_busy_pre", {31'd0, o_fu_busy[1]}, 32'd1);
        i_flush = 1'b1;
        drive_op(0, 3'd4, 6'd8);
        #1;
        check("flush_suppress", {28'd0, o_issueSuccess, o_issueReplay}, 32'd0);
        check("flush_vld", {30'd0, o_fu_vld}, 32'd0);
        step();
        check("flush_busy_clr", {31'd0, o_fu_busy[1]}, 32'd0);
        check("flush_ren", {30'd0, o_rf_ren}, 32'd0);
        step();
        step();

        // Asynchronous reset between edges with ops in flight.
        drive_op(0, 3'd6, 6'd11);
        step();
        drive_op(1, 3'd7, 6'd12);
        #2;
        i_can_issue = 2'b00;
        rst         = 1'b0;
        i_fu_stall  = 2'b01;
        #1;
        check("arst_ren", {30'd0, o_rf_ren}, 32'd0);
        check("arst_iprs0", {26'd0, o_rf_iprs[0]}, 32'd0);
        check("arst_fb", {28'd0, o_issueSuccess, o_issueReplay}, 32'd0);
        check("arst_vld", {30'd0, o_fu_vld}, 32'd0);
        check("arst_busy", {30'd0, o_fu_busy}, 32'd0);
`ifdef MEM_ISSUE_PERF_EN
        check("arst_perf_s", o_perf_success, 32'd0);
        check("arst_perf_r", o_perf_replay, 32'd0);
`endif
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Both ports in parallel: four successes then two replays.
        drive_op(0, 3'd1, 6'd1);
        drive_op(1, 3'd3, 6'd3);
        expect_fb(0, 1'b1, 3'd1);
        expect_fb(1, 1'b1, 3'd3);
        step();
        drive_op(0, 3'd2, 6'd2);
        drive_op(1, 3'd4, 6'd4);
        expect_fb(0, 1'b1, 3'd2);
        expect_fb(1, 1'b1, 3'd4);
        step();
        drive_op(0, 3'd5, 6'd5);
        drive_op(1, 3'd6, 6'd6);
        expect_fb(0, 1'b0, 3'd5);
        expect_fb(1, 1'b0, 3'd6);
        step();
        step();
        i_fu_stall[0]  = 1'b1;
        i_cancel_i2[1] = 1'b1;
        for (int k = 0; k < 4; k++) step();
`ifdef MEM_ISSUE_PERF_EN
        check("perf_success", o_perf_success, 32'd4);
        check("perf_replay", o_perf_replay, 32'd2);
`endif

        // Every expected feedback must have been seen.
        step();
        step();
        check("sb_drain0", sb_q0.size(), 32'd0);
        check("sb_drain1", sb_q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
